led_scanner_pwm: RTL and testbench
==================================

// Module: led_scanner_pwm
// PURPOSE
//  Parametrised "scanner" LED driver: a bright head sweeps across NUM_LEDS outputs, and its
//  neighbours cross-fade by PWM according to the sub-position. Next generation of the badge
//  blink/scan block: configurable channel count, PWM depth and speed, plus bounce/chase/hold/off
//  modes. Sits between the top-level clock and the LED pins, or behind a small control register.
// PARAMETERS
//  NUM_LEDS       8   number of LED channels (>=2, any value, not restricted to powers of 2)
//  PWM_BITS       10  PWM resolution; BMAX = 2**PWM_BITS-1
//  POS_FRAC_BITS  21  sub-position bits per LED slot (must be >= PWM_BITS)
//  SPEED_BITS     4   width of step input
//  (local) IDX_BITS = $clog2(NUM_LEDS); POS_MAX = NUM_LEDS*2**POS_FRAC_BITS-1
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           asynchronous active-low reset
//  en         in   1           1: position advances; 0: position/dir frozen, display continues
//  mode       in   2           00 off, 01 bounce, 10 chase (wrap), 11 hold
//  step       in   SPEED_BITS  position increment per enabled cycle (0 = stationary)
//  led        out  NUM_LEDS    PWM outputs, active high, registered
//  head       out  IDX_BITS    current head index = pos >> POS_FRAC_BITS
//  dir        out  1           0 forward (increasing index), 1 reverse
//  turn       out  1           1-cycle pulse on a bounce turnaround or chase wrap
// BEHAVIOUR
//  Reset (async assert, sync release): pos=0, dir=0, pwm_ctr=0, all brightness=0, led=0, turn=0.
//  pwm_ctr: free-running PWM_BITS counter, runs in all modes except under reset.
//  Position update each cycle (pos width IDX_BITS+POS_FRAC_BITS; compare in 1 extra bit):
//   mode 00: pos<=0, dir<=0, turn<=0; brightness forced 0 (led all 0 two cycles later).
//   mode 11, or en=0: pos, dir held; turn<=0.
//   mode 01 fwd: if pos+step > POS_MAX -> pos<=POS_MAX, dir<=1, turn<=1; else pos<=pos+step.
//   mode 01 rev: if pos < step -> pos<=0, dir<=0, turn<=1; else pos<=pos-step.
//   mode 10 fwd: if pos+step > POS_MAX -> pos<=pos+step-(POS_MAX+1), turn<=1; dir unchanged.
//   mode 10 rev: if pos < step -> pos<=pos+(POS_MAX+1)-step, turn<=1; dir unchanged.
//   pos never exceeds POS_MAX; head never >= NUM_LEDS.
//  Brightness (registered, per channel i), idx=head, frac=pos[POS_FRAC_BITS-1 -: PWM_BITS]:
//   i==idx -> BMAX; i==idx+1 -> frac (fade-in ahead); i==idx-1 -> BMAX-frac (fade-out behind);
//   else 0. Mode 10: idx+-1 wrap modulo NUM_LEDS. Mode 01/11: no wrap (off-end neighbour absent).
//   Mode 11 uses mode-01 neighbour rules.
//  led[i] <= (pwm_ctr < brightness[i]); BMAX => high 2**PWM_BITS-1 of 2**PWM_BITS cycles.
//  Latency: pos register change -> brightness 1 cycle -> led 1 further cycle (2 total).
//  Mode change takes effect on the next clock; bounce->chase keeps dir; chase->bounce keeps pos/dir.
//  Reset mid-operation: all state returns to reset values immediately, regardless of mode/en.
//  head, dir, turn are direct register outputs (no extra latency vs pos/dir registers).
// TESTING  (bench params: NUM_LEDS=4, PWM_BITS=4, POS_FRAC_BITS=4 -> POS_MAX=63)
//  1 rst_n=0 mid-run -> led=0, head=0, dir=0, turn=0 at once; release, mode=01, step=1, en=1 ->
//    head=1 after exactly 16 enabled cycles.
//  2 mode=01, pos=60, step=5 -> pos=63, dir=1, turn=1 for one cycle; next cycle pos=58, turn=0.
//  3 mode=10, dir=0, pos=62, step=3 -> pos=1, turn=1, dir stays 0; rev at pos=1, step=3 -> pos=62.
//  4 mode=11, pos=40 (idx 2, frac 8), 16-cycle window -> led[2] high 15, led[3] high 8,
//    led[1] high 7, led[0] high 0 cycles.
//  5 mode=10, pos=56 (idx 3, frac 8) -> led[0] high 8/16 (wrapped fade-in); mode=01 same pos -> led[0]=0.
//  6 mode=00 from running -> pos=0, dir=0; led all 0 within 2 cycles; en=0 in mode 01 -> pos frozen.

Source files
------------

// File: rtl/led_scanner_pwm.sv
// Scanner LED driver: a full-brightness head sweeps across NUM_LEDS channels
// while its two neighbours cross-fade by PWM according to the sub-slot
// position. Modes: off, bounce (reverse at the ends), chase (wrap), hold.
module led_scanner_pwm #(
  parameter int NUM_LEDS      = 8,
  parameter int PWM_BITS      = 10,
  parameter int POS_FRAC_BITS = 21,
  parameter int SPEED_BITS    = 4,
  localparam int IDX_BITS     = $clog2(NUM_LEDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SPEED_BITS-1:0] step,
  output logic [NUM_LEDS-1:0]   led,
  output logic [IDX_BITS-1:0]   head,
  output logic                  dir,
  output logic                  turn
);

  localparam int POS_W = IDX_BITS + POS_FRAC_BITS;
  // Position arithmetic is done one bit wider so overflow past the end is visible.
  localparam logic [POS_W:0]    POS_MAX_X = (POS_W+1)'(NUM_LEDS * (2**POS_FRAC_BITS) - 1);
  localparam logic [POS_W:0]    POS_LIM_X = (POS_W+1)'(NUM_LEDS * (2**POS_FRAC_BITS));
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(NUM_LEDS * (2**POS_FRAC_BITS) - 1);
  localparam logic [PWM_BITS-1:0] BMAX    = {PWM_BITS{1'b1}};
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [POS_W-1:0]    pos_r;
  logic                dir_r;
  logic                turn_r;
  logic [PWM_BITS-1:0] pwm_ctr_r;
  logic [PWM_BITS-1:0] bright_r [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_r;

  logic [POS_W:0]      pos_x_s;
  logic [POS_W:0]      step_x_s;
  logic [POS_W:0]      sum_s;
  logic [POS_W-1:0]    pos_nxt_s;
  logic                dir_nxt_s;
  logic                turn_nxt_s;
  logic [IDX_BITS-1:0] idx_s;
  logic [PWM_BITS-1:0] frac_s;
  logic [IDX_BITS-1:0] nxt_idx_s;
  logic [IDX_BITS-1:0] prv_idx_s;
  logic                nxt_vld_s;
  logic                prv_vld_s;
  logic [PWM_BITS-1:0] bright_nxt_s [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_nxt_s;

  assign idx_s  = pos_r[POS_W-1 -: IDX_BITS];
  assign frac_s = pos_r[POS_FRAC_BITS-1 -: PWM_BITS];
  assign head   = idx_s;
  assign dir    = dir_r;
  assign turn   = turn_r;
  assign led    = led_r;

  // Next position / direction / turnaround pulse from mode, enable and step.
  always_comb begin
    pos_x_s    = {1'b0, pos_r};
    step_x_s   = (POS_W+1)'(step);
    sum_s      = pos_x_s + step_x_s;
    pos_nxt_s  = pos_r;
    dir_nxt_s  = dir_r;
    turn_nxt_s = 1'b0;
    case (mode)
      MODE_OFF: begin
        pos_nxt_s = '0;
        dir_nxt_s = 1'b0;
      end
      MODE_BOUNCE: begin
        if (!en) begin
          pos_nxt_s = pos_r;
        end else if (!dir_r) begin
          if (sum_s > POS_MAX_X) begin
            pos_nxt_s  = POS_MAX;
            dir_nxt_s  = 1'b1;
            turn_nxt_s = 1'b1;
          end else begin
            pos_nxt_s = POS_W'(sum_s);
          end
        end else begin
          if (pos_x_s < step_x_s) begin
            pos_nxt_s  = '0;
            dir_nxt_s  = 1'b0;
            turn_nxt_s = 1'b1;
          end else begin
            pos_nxt_s = POS_W'(pos_x_s - step_x_s);
          end
        end
      end
      MODE_CHASE: begin
        if (!en) begin
          pos_nxt_s = pos_r;
        end else if (!dir_r) begin
          if (sum_s > POS_MAX_X) begin
            pos_nxt_s  = POS_W'(sum_s - POS_LIM_X);
            turn_nxt_s = 1'b1;
          end else begin
            pos_nxt_s = POS_W'(sum_s);
          end
        end else begin
          if (pos_x_s < step_x_s) begin
            pos_nxt_s  = POS_W'(pos_x_s + POS_LIM_X - step_x_s);
            turn_nxt_s = 1'b1;
          end else begin
            pos_nxt_s = POS_W'(pos_x_s - step_x_s);
          end
        end
      end
      MODE_HOLD: begin
        pos_nxt_s = pos_r;
      end
      default: begin
        pos_nxt_s = pos_r;
      end
    endcase
  end

  // Neighbour indices; chase wraps around, bounce/hold drop the off-end neighbour.
  always_comb begin
    nxt_idx_s = idx_s + IDX_BITS'(1);
    prv_idx_s = idx_s - IDX_BITS'(1);
    nxt_vld_s = 1'b1;
    prv_vld_s = 1'b1;
    if (idx_s == IDX_LAST) begin
      nxt_idx_s = '0;
      nxt_vld_s = (mode == MODE_CHASE);
    end else begin
      nxt_vld_s = 1'b1;
    end
    if (idx_s == '0) begin
      prv_idx_s = IDX_LAST;
      prv_vld_s = (mode == MODE_CHASE);
    end else begin
      prv_vld_s = 1'b1;
    end
  end

  // Per-channel brightness target and PWM compare against the current counter.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      bright_nxt_s[i] = '0;
      if (mode == MODE_OFF) begin
        bright_nxt_s[i] = '0;
      end else if (IDX_BITS'(i) == idx_s) begin
        bright_nxt_s[i] = BMAX;
      end else if (nxt_vld_s && (IDX_BITS'(i) == nxt_idx_s)) begin
        bright_nxt_s[i] = frac_s;
      end else if (prv_vld_s && (IDX_BITS'(i) == prv_idx_s)) begin
        bright_nxt_s[i] = BMAX - frac_s;
      end else begin
        bright_nxt_s[i] = '0;
      end
      led_nxt_s[i] = (pwm_ctr_r < bright_r[i]);
    end
  end

  // State registers: position, direction, turn pulse, PWM counter, brightness, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r     <= '0;
      dir_r     <= 1'b0;
      turn_r    <= 1'b0;
      pwm_ctr_r <= '0;
      led_r     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        bright_r[i] <= '0;
      end
    end else begin
      pos_r     <= pos_nxt_s;
      dir_r     <= dir_nxt_s;
      turn_r    <= turn_nxt_s;
      pwm_ctr_r <= pwm_ctr_r + PWM_BITS'(1);
      led_r     <= led_nxt_s;
      for (int i = 0; i < NUM_LEDS; i++) begin
        bright_r[i] <= bright_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_led_scanner_pwm.sv
// Directed bench for led_scanner_pwm with NUM_LEDS=4, PWM_BITS=4, POS_FRAC_BITS=4.
module tb_led_scanner_pwm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] step;
  logic [3:0] led;
  logic [1:0] head;
  logic       dir;
  logic       turn;

  int pass_cnt = 0;
  int total_cnt = 0;
  int hi_cnt [4];

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] step;
    logic [5:0] pos;
    logic       dir;
    logic       turn;
  } vec_t;

  vec_t vecs[$];

  led_scanner_pwm #(
    .NUM_LEDS(4), .PWM_BITS(4), .POS_FRAC_BITS(4), .SPEED_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
    .led(led), .head(head), .dir(dir), .turn(turn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int e, input int m, input int s,
                               input int p, input int d, input int t);
    vec_t v;
    v.en = 1'(e); v.mode = 2'(m); v.step = 4'(s);
    v.pos = 6'(p); v.dir = 1'(d); v.turn = 1'(t);
    vecs.push_back(v);
  endfunction

  task automatic drive(input int e, input int m, input int s);
    en = 1'(e); mode = 2'(m); step = 4'(s);
  endtask

  // Count high cycles per LED over one full 16-cycle PWM window.
  task automatic measure();
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < 4; i++) if (led[i]) hi_cnt[i]++;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive(0, 0, 0);
    #8;
    chk("rst_led", int'(led), 0);
    chk("rst_head", int'(head), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_turn", int'(turn), 0);
    #4 rst_n = 1'b1;

    // en, mode, step -> expected pos, dir, turn after the clock edge
    push(1,1,15, 15,0,0); push(1,1,15, 30,0,0); push(1,1,15, 45,0,0);
    push(1,1,15, 60,0,0); push(1,1, 5, 63,1,1); push(1,1, 5, 58,1,0);
    push(0,1, 5, 58,1,0); push(1,3, 5, 58,1,0); push(1,1,15, 43,1,0);
    push(1,1,15, 28,1,0); push(1,1,15, 13,1,0); push(1,1,15,  0,0,1);
    push(1,1, 0,  0,0,0); push(1,2,15, 15,0,0); push(1,2,15, 30,0,0);
    push(1,2,15, 45,0,0); push(1,2,15, 60,0,0); push(1,2, 2, 62,0,0);
    push(1,2, 3,  1,0,1); push(1,2, 0,  1,0,0); push(1,1,15, 16,0,0);
    push(1,1,15, 31,0,0); push(1,1,15, 46,0,0); push(1,1,15, 61,0,0);
    push(1,1,15, 63,1,1); push(1,1,15, 48,1,0); push(1,1,15, 33,1,0);
    push(1,1,15, 18,1,0); push(1,1,15,  3,1,0); push(1,1, 2,  1,1,0);
    push(1,2, 3, 62,1,1); push(1,2, 3, 59,1,0); push(1,0, 3,  0,0,0);
    push(0,0, 3,  0,0,0);

    foreach (vecs[k]) begin
      drive(int'(vecs[k].en), int'(vecs[k].mode), int'(vecs[k].step));
      tick();
      chk($sformatf("vec%0d_pos", k), int'(dut.pos_r), int'(vecs[k].pos));
      chk($sformatf("vec%0d_head", k), int'(head), int'(vecs[k].pos) / 16);
      chk($sformatf("vec%0d_dir", k), int'(dir), int'(vecs[k].dir));
      chk($sformatf("vec%0d_turn", k), int'(turn), int'(vecs[k].turn));
    end

    // Hold at pos 40 (idx 2, frac 8): head full, neighbours 8 and 7.
    drive(1, 1, 15); tick(); tick();
    drive(1, 1, 10); tick();
    chk("pos40", int'(dut.pos_r), 40);
    drive(1, 3, 10); tick(); tick(); tick();
    measure();
    chk("hold_led0", hi_cnt[0], 0);
    chk("hold_led1", hi_cnt[1], 7);
    chk("hold_led2", hi_cnt[2], 15);
    chk("hold_led3", hi_cnt[3], 8);

    // pos 56 (idx 3, frac 8): chase wraps the fade-in onto led0, bounce drops it.
    drive(1, 1, 15); tick();
    drive(1, 1, 1); tick();
    chk("pos56", int'(dut.pos_r), 56);
    drive(0, 2, 1); tick(); tick(); tick();
    measure();
    chk("chase_led0", hi_cnt[0], 8);
    chk("chase_led1", hi_cnt[1], 0);
    chk("chase_led2", hi_cnt[2], 7);
    chk("chase_led3", hi_cnt[3], 15);
    chk("chase_en0_pos", int'(dut.pos_r), 56);
    drive(0, 1, 1); tick(); tick(); tick();
    measure();
    chk("bounce_led0", hi_cnt[0], 0);
    chk("bounce_led2", hi_cnt[2], 7);
    chk("bounce_led3", hi_cnt[3], 15);

    // Mode off from running: leds dark two cycles later and stay dark.
    drive(1, 1, 15); tick();
    chk("pre_off_dir", int'(dir), 1);
    tick();
    drive(1, 0, 15); tick(); tick();
    chk("off_led", int'(led), 0);
    chk("off_pos", int'(dut.pos_r), 0);
    chk("off_dir", int'(dir), 0);
    measure();
    chk("off_led_window", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

    // Reset mid-run with the head reversing and LEDs lit.
    drive(1, 1, 15);
    repeat (6) tick();
    chk("pre_rst_dir", int'(dir), 1);
    chk("pre_rst_head", int'(head), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_led", int'(led), 0);
    chk("midrst_head", int'(head), 0);
    chk("midrst_dir", int'(dir), 0);
    chk("midrst_turn", int'(turn), 0);
    drive(1, 1, 1);
    tick(); tick();
    #2 rst_n = 1'b1;
    n = 0;
    while (n <= 20) begin
      tick();
      n++;
      if (head == 2'd1) break;
    end
    chk("head1_cycles", n, 16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
